// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control signal bundle between the RV32 pipeline datapath and pipeline_hazard_ctrl.
// The datapath side is master (drives register ids/status), the controller is slave.
interface pipeline_hazard_ctrl_if;
   logic [4:0] Rs1D, Rs2D;
   logic [4:0] Rs1E, Rs2E, RdE;
   logic [4:0] RdM, RdW;
   logic       RegWriteM, RegWriteW;
   logic [1:0] ResultSrcE;
   logic       PCSrcE;
   logic       MemReqM, MemReadyM;
   logic       StallF, StallD, StallE, StallM;
   logic       FlushD, FlushE, FlushW;
   logic [1:0] ForwardAE, ForwardBE;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
             ResultSrcE, PCSrcE, MemReqM, MemReadyM,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAE, ForwardBE
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
             ResultSrcE, PCSrcE, MemReqM, MemReadyM,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAE, ForwardBE
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV32 pipeline (warm-up, load-use, mem wait).
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int unsigned INIT_CYC    = 2,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipeline_hazard_ctrl_if.slave hz,
   output logic [1:0]            state,
   output logic                  mem_timeout_err,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt,
   output logic [31:0]           memwait_cnt
);
   typedef enum logic [1:0] {
      S_INIT    = 2'b00,
      S_RUN     = 2'b01,
      S_MEMWAIT = 2'b10,
      S_ABORT   = 2'b11
   } state_t;

   localparam logic [3:0] INIT_LAST = 4'(INIT_CYC - 1);
   localparam logic [7:0] WAIT_MAX  = 8'(MEM_TIMEOUT);

   state_t     st;
   logic [3:0] init_cnt;
   logic [7:0] wait_cnt;

   logic mem_miss, load_use;
   logic stall_f, stall_d, stall_e, stall_m;
   logic flush_d, flush_e, flush_w;

   // M-stage result is younger than W, so it takes priority.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic wm, input logic [4:0] rdm,
                                          input logic ww, input logic [4:0] rdw);
      if (wm && (rdm != 5'd0) && (rdm == rs))      return 2'b10;
      else if (ww && (rdw != 5'd0) && (rdw == rs)) return 2'b01;
      else                                         return 2'b00;
   endfunction

   always_comb begin
      mem_miss = hz.MemReqM & ~hz.MemReadyM;
      load_use = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                 ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      unique case (st)
         S_INIT: begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end
         S_RUN, S_MEMWAIT: begin
            // While waiting, the branch in E is frozen and re-evaluated once memory answers.
            if ((st == S_RUN && mem_miss) || (st == S_MEMWAIT && !hz.MemReadyM)) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               stall_m = 1'b1;
               flush_w = 1'b1;
            end else if (hz.PCSrcE) begin
               flush_d = 1'b1;
               flush_e = 1'b1;
            end else if (load_use) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end
         end
         S_ABORT: begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
         end
      endcase
   end

   assign hz.StallF    = stall_f;
   assign hz.StallD    = stall_d;
   assign hz.StallE    = stall_e;
   assign hz.StallM    = stall_m;
   assign hz.FlushD    = flush_d;
   assign hz.FlushE    = flush_e;
   assign hz.FlushW    = flush_w;
   assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
   assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
   assign state        = st;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st              <= S_INIT;
         init_cnt        <= 4'd0;
         wait_cnt        <= 8'd0;
         mem_timeout_err <= 1'b0;
      end else begin
         unique case (st)
            S_INIT: begin
               init_cnt <= init_cnt + 4'd1;
               if (init_cnt == INIT_LAST) st <= S_RUN;
            end
            S_RUN: begin
               if (mem_miss) begin
                  st       <= S_MEMWAIT;
                  wait_cnt <= 8'd1;
               end
            end
            S_MEMWAIT: begin
               // A ready arriving on the timeout cycle still completes the access.
               if (hz.MemReadyM) begin
                  st       <= S_RUN;
                  wait_cnt <= 8'd0;
               end else if (wait_cnt == WAIT_MAX) begin
                  st              <= S_ABORT;
                  wait_cnt        <= 8'd0;
                  mem_timeout_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_ABORT: st <= S_RUN;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_q, flush_q, memwait_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q   <= 32'd0;
         flush_q   <= 32'd0;
         memwait_q <= 32'd0;
      end else begin
         if (stall_f)                   stall_q   <= stall_q + 32'd1;
         if (flush_e && st != S_INIT)   flush_q   <= flush_q + 32'd1;
         if (st == S_MEMWAIT)           memwait_q <= memwait_q + 32'd1;
      end
   end

   assign stall_cnt   = stall_q;
   assign flush_cnt   = flush_q;
   assign memwait_cnt = memwait_q;
`else
   assign stall_cnt   = 32'd0;
   assign flush_cnt   = 32'd0;
   assign memwait_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expectations queued with each step, checked on the falling edge.
// Perf-counter expectations follow HAZARD_PERF_EN.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz ();

  logic [1:0]  state;
  logic        err;
  logic [31:0] stall_cnt, flush_cnt, memwait_cnt;

  pipeline_hazard_ctrl #(.INIT_CYC(2), .MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hz             (hz),
    .state          (state),
    .mem_timeout_err(err),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .memwait_cnt    (memwait_cnt)
  );

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] FLSH  = 7'b0000110;
  localparam logic [6:0] MEMST = 7'b1111001;
  localparam logic [6:0] LU    = 7'b1100010;
  localparam logic [6:0] ABT   = 7'b0000111;
  localparam logic [1:0] S_INIT = 2'b00, S_RUN = 2'b01, S_MW = 2'b10, S_AB = 2'b11;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [13:0] ctrl_vec;
  assign ctrl_vec = {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                     hz.FlushD, hz.FlushE, hz.FlushW,
                     hz.ForwardAE, hz.ForwardBE, state, err};

  always @(negedge clk) begin : monitor
    item_t       it;
    logic [31:0] o;
    while (q.size() > 0) begin
      it = q.pop_front();
      case (it.sel)
        0:       o = {18'd0, ctrl_vec};
        1:       o = stall_cnt;
        2:       o = flush_cnt;
        default: o = memwait_cnt;
      endcase
      checks++;
      assert (o === it.exp) passed++;
      else begin
        failed++;
        $error("FAIL %s observed=%h expected=%h", it.tag, o, it.exp);
      end
    end
  end

  task automatic exp_ctl(input string tag, input logic [6:0] sf,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [1:0] st, input logic e);
    item_t it;
    it.tag = tag;
    it.sel = 0;
    it.exp = {18'd0, sf, fa, fb, st, e};
    q.push_back(it);
  endtask

  task automatic exp_cnt(input string tag, input int sel, input logic [31:0] v);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = v;
    q.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
    hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE = 2'b00;
    hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;

    // reset and warm-up
    tick();
    checks++;
    if (state === S_INIT && err === 1'b0 && hz.FlushD === 1'b1 && hz.FlushE === 1'b1 &&
        hz.StallF === 1'b0 && hz.StallD === 1'b0 && hz.StallE === 1'b0 &&
        hz.StallM === 1'b0 && hz.FlushW === 1'b0) passed++;
    else begin
      failed++;
      $error("FAIL reset_state state=%b err=%b ctrl=%b", state, err, ctrl_vec);
    end
    exp_ctl("reset", FLSH, 2'b00, 2'b00, S_INIT, 1'b0);
    exp_cnt("reset_stall_cnt", 1, 32'd0);
    exp_cnt("reset_flush_cnt", 2, 32'd0);
    exp_cnt("reset_memwait_cnt", 3, 32'd0);
    tick();
    rst_n = 1'b1;
    exp_ctl("init1", FLSH, 2'b00, 2'b00, S_INIT, 1'b0); tick();
    exp_ctl("init2", FLSH, 2'b00, 2'b00, S_INIT, 1'b0); tick();
    exp_ctl("run0", NONE, 2'b00, 2'b00, S_RUN, 1'b0); tick();

    // load-use
    hz.ResultSrcE = 2'b01; hz.RdE = 5'd5; hz.Rs1D = 5'd5;
    exp_ctl("lu_rs1", LU, 2'b00, 2'b00, S_RUN, 1'b0); tick();
    hz.ResultSrcE = 2'b00; hz.RdE = 5'd0;
    exp_ctl("lu_done", NONE, 2'b00, 2'b00, S_RUN, 1'b0); tick();
    hz.ResultSrcE = 2'b01; hz.RdE = 5'd0; hz.Rs1D = 5'd0;
    exp_ctl("lu_x0", NONE, 2'b00, 2'b00, S_RUN, 1'b0); tick();
    hz.ResultSrcE = 2'b00;

    // mem wait with a pending branch
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0; hz.PCSrcE = 1'b1;
    exp_ctl("mw_run", MEMST, 2'b00, 2'b00, S_RUN, 1'b0); tick();
    exp_ctl("mw_1", MEMST, 2'b00, 2'b00, S_MW, 1'b0); tick();
    exp_ctl("mw_2", MEMST, 2'b00, 2'b00, S_MW, 1'b0); tick();
    hz.MemReadyM = 1'b1;
    exp_ctl("mw_ready_branch", FLSH, 2'b00, 2'b00, S_MW, 1'b0); tick();
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0; hz.PCSrcE = 1'b0;
    exp_ctl("mw_back", NONE, 2'b00, 2'b00, S_RUN, 1'b0);
    exp_cnt("perf_stall_cnt", 1, PERF ? 32'd4 : 32'd0);
    exp_cnt("perf_flush_cnt", 2, PERF ? 32'd2 : 32'd0);
    exp_cnt("perf_memwait_cnt", 3, PERF ? 32'd3 : 32'd0);
    tick();

    // forwarding
    hz.RdM = 5'd7; hz.RdW = 5'd7; hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1; hz.Rs1E = 5'd7;
    exp_ctl("fwd_m", NONE, 2'b10, 2'b00, S_RUN, 1'b0); tick();
    hz.RegWriteM = 1'b0;
    exp_ctl("fwd_w", NONE, 2'b01, 2'b00, S_RUN, 1'b0); tick();
    hz.RegWriteM = 1'b1; hz.RdM = 5'd0; hz.RdW = 5'd0;
    exp_ctl("fwd_x0", NONE, 2'b00, 2'b00, S_RUN, 1'b0); tick();
    hz.RdM = 5'd3; hz.RdW = 5'd7; hz.Rs1E = 5'd3; hz.Rs2E = 5'd7;
    exp_ctl("fwd_ab", NONE, 2'b10, 2'b01, S_RUN, 1'b0); tick();
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    exp_ctl("fwd_off", NONE, 2'b00, 2'b00, S_RUN, 1'b0); tick();

    // load-use on rs2, branch priority, same-cycle memory hit
    hz.ResultSrcE = 2'b01; hz.RdE = 5'd9; hz.Rs1D = 5'd1; hz.Rs2D = 5'd9;
    exp_ctl("lu_rs2", LU, 2'b00, 2'b00, S_RUN, 1'b0); tick();
    hz.PCSrcE = 1'b1;
    exp_ctl("br_over_lu", FLSH, 2'b00, 2'b00, S_RUN, 1'b0); tick();
    hz.PCSrcE = 1'b0; hz.ResultSrcE = 2'b00; hz.RdE = 5'd0;
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b1;
    exp_ctl("mem_hit", NONE, 2'b00, 2'b00, S_RUN, 1'b0); tick();

    // timeout and abort
    hz.MemReadyM = 1'b0;
    exp_ctl("to_run", MEMST, 2'b00, 2'b00, S_RUN, 1'b0); tick();
    for (int i = 1; i <= 4; i++) begin
      exp_ctl($sformatf("to_wait%0d", i), MEMST, 2'b00, 2'b00, S_MW, 1'b0);
      tick();
    end
    checks++;
    if (state === S_AB && err === 1'b1 && hz.FlushD === 1'b1 && hz.FlushE === 1'b1 &&
        hz.FlushW === 1'b1 && hz.StallM === 1'b0) passed++;
    else begin
      failed++;
      $error("FAIL expired_wait state=%b err=%b ctrl=%b", state, err, ctrl_vec);
    end
    hz.MemReqM = 1'b0;
    exp_ctl("abort", ABT, 2'b00, 2'b00, S_AB, 1'b1); tick();
    exp_ctl("after_abort", NONE, 2'b00, 2'b00, S_RUN, 1'b1); tick();
    exp_ctl("err_sticky", NONE, 2'b00, 2'b00, S_RUN, 1'b1); tick();

    // reset in the middle of a wait
    hz.MemReqM = 1'b1;
    exp_ctl("rw_run", MEMST, 2'b00, 2'b00, S_RUN, 1'b1); tick();
    exp_ctl("rw_wait", MEMST, 2'b00, 2'b00, S_MW, 1'b1); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; hz.MemReqM = 1'b0;
    exp_ctl("rw_init1", FLSH, 2'b00, 2'b00, S_INIT, 1'b0);
    exp_cnt("rw_stall_cnt", 1, 32'd0);
    exp_cnt("rw_memwait_cnt", 3, 32'd0);
    tick();
    exp_ctl("rw_init2", FLSH, 2'b00, 2'b00, S_INIT, 1'b0); tick();
    exp_ctl("rw_run0", NONE, 2'b00, 2'b00, S_RUN, 1'b0); tick();

    // ready on the timeout cycle wins
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    exp_ctl("rt_run", MEMST, 2'b00, 2'b00, S_RUN, 1'b0); tick();
    for (int i = 1; i <= 3; i++) begin
      exp_ctl($sformatf("rt_wait%0d", i), MEMST, 2'b00, 2'b00, S_MW, 1'b0);
      tick();
    end
    hz.MemReadyM = 1'b1;
    exp_ctl("rt_ready_at_limit", NONE, 2'b00, 2'b00, S_MW, 1'b0); tick();
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
    exp_ctl("rt_no_err", NONE, 2'b00, 2'b00, S_RUN, 1'b0); tick();

    if (failed != 0) $display("%0d checks did not match", failed);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
